// File: rtl/spi_bus_arbiter_if.sv
// Handshake/bus bundle between the two SPI requesters, the arbiter and the shared SPI master.
// The arbiter uses the slave modport; the requester/master environment uses the master modport.
interface spi_bus_arbiter_if;
  logic [1:0] req_i;
  logic [1:0] start_i;
  logic [7:0] tx_data_sensor_i;
  logic [7:0] tx_data_sd_i;
  logic [1:0] gnt_o;
  logic [1:0] done_o;
  logic [7:0] rx_data_o;
  logic       timeout_o;
  logic       spi_start_o;
  logic [7:0] spi_tx_data_o;
  logic [7:0] spi_rx_data_i;
  logic       spi_done_i;
  logic       cs_sensor_o;
  logic       cs_sd_o;

  modport slave (
    input  req_i, start_i, tx_data_sensor_i, tx_data_sd_i, spi_rx_data_i, spi_done_i,
    output gnt_o, done_o, rx_data_o, timeout_o, spi_start_o, spi_tx_data_o, cs_sensor_o, cs_sd_o
  );

  modport master (
    output req_i, start_i, tx_data_sensor_i, tx_data_sd_i, spi_rx_data_i, spi_done_i,
    input  gnt_o, done_o, rx_data_o, timeout_o, spi_start_o, spi_tx_data_o, cs_sensor_o, cs_sd_o
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI byte master between the light sensor (0) and SD card (1) with burst fairness and a watchdog.
// Optional: define ARB_FIXED_PRIORITY_EN for sensor-first ties and SD-only burst preemption.
module spi_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned MAX_BURST      = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  spi_bus_arbiter_if.slave bus
);
  localparam int unsigned    TCW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned    BCW     = $clog2(MAX_BURST + 1);
  localparam logic [TCW-1:0] TC_LAST = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [BCW-1:0] BC_MAX  = BCW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, GRANT, XFER, RELEASE} state_t;

  state_t         state_q, state_d;
  logic           owner_q, owner_d;
  logic [BCW-1:0] bcnt_q, bcnt_d, bcnt_inc;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           preempt;

  logic [1:0] gnt_d, done_d;
  logic [7:0] tx_d, rx_d;
  logic       timeout_d, spi_start_d, cs_sensor_d, cs_sd_d;

  assign bcnt_inc = (bcnt_q == BC_MAX) ? bcnt_q : bcnt_q + BCW'(1);

`ifdef ARB_FIXED_PRIORITY_EN
  assign preempt = owner_q && (bcnt_inc == BC_MAX) && bus.req_i[0];
`else
  assign preempt = (bcnt_inc == BC_MAX) && bus.req_i[~owner_q];
`endif

  // owner_q doubles as the last-served pointer once the bus is released
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_i != 2'b00) begin
          state_d = GRANT;
          if (bus.req_i == 2'b01)      owner_d = 1'b0;
          else if (bus.req_i == 2'b10) owner_d = 1'b1;
          else begin
`ifdef ARB_FIXED_PRIORITY_EN
            owner_d = 1'b0;
`else
            owner_d = ~owner_q;
`endif
          end
        end
      end
      GRANT: begin
        if (!bus.req_i[owner_q])        state_d = RELEASE;
        else if (bus.start_i[owner_q])  state_d = XFER;
      end
      XFER: begin
        if (bus.spi_done_i) begin
          if (!bus.req_i[owner_q] || preempt) state_d = RELEASE;
          else                                state_d = GRANT;
        end else if (tcnt_q == TC_LAST) begin
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bcnt_d      = bcnt_q;
    tcnt_d      = tcnt_q;
    done_d      = '0;
    timeout_d   = 1'b0;
    spi_start_d = 1'b0;
    tx_d        = bus.spi_tx_data_o;
    rx_d        = bus.rx_data_o;
    unique case (state_q)
      IDLE: if (state_d == GRANT) bcnt_d = '0;
      GRANT: begin
        if (state_d == XFER) begin
          tx_d        = owner_q ? bus.tx_data_sd_i : bus.tx_data_sensor_i;
          spi_start_d = 1'b1;
          tcnt_d      = '0;
        end
      end
      XFER: begin
        // a done in the final watchdog cycle still completes the byte
        if (bus.spi_done_i) begin
          rx_d            = bus.spi_rx_data_i;
          done_d[owner_q] = 1'b1;
          bcnt_d          = bcnt_inc;
        end else if (tcnt_q == TC_LAST) begin
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TCW'(1);
        end
      end
      default: ;
    endcase

    gnt_d       = '0;
    cs_sensor_d = 1'b1;
    cs_sd_d     = 1'b1;
    if (state_d == GRANT || state_d == XFER) begin
      gnt_d[owner_d] = 1'b1;
      if (owner_d) cs_sd_d     = 1'b0;
      else         cs_sensor_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bcnt_q            <= '0;
      tcnt_q            <= '0;
      bus.gnt_o         <= '0;
      bus.done_o        <= '0;
      bus.timeout_o     <= 1'b0;
      bus.spi_start_o   <= 1'b0;
      bus.spi_tx_data_o <= '0;
      bus.rx_data_o     <= '0;
      bus.cs_sensor_o   <= 1'b1;
      bus.cs_sd_o       <= 1'b1;
    end else begin
      bcnt_q            <= bcnt_d;
      tcnt_q            <= tcnt_d;
      bus.gnt_o         <= gnt_d;
      bus.done_o        <= done_d;
      bus.timeout_o     <= timeout_d;
      bus.spi_start_o   <= spi_start_d;
      bus.spi_tx_data_o <= tx_d;
      bus.rx_data_o     <= rx_d;
      bus.cs_sensor_o   <= cs_sensor_d;
      bus.cs_sd_o       <= cs_sd_d;
    end
  end
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: an SPI master model answers each start with tx ^ 0x99.
// Expected bytes/completions are queued at strobe time and popped by the output monitor.
module tb_spi_bus_arbiter;
  localparam int unsigned TO     = 1000;
  localparam int unsigned MB     = 16;
  localparam int          K_DONE = 0;
  localparam int          K_TO   = 1;
  localparam int          K_NONE = 2;

  typedef struct {
    logic [1:0] who;
    logic [7:0] rx;
    bit         is_to;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned n_checks = 0, n_fail = 0;
  int unsigned cyc = 0, n_done = 0, n_to = 0, n_start = 0, t_start = 0;
  int unsigned m_lat = 80;
  exp_t        exp_q[$];
  logic [7:0]  exp_tx[$];

  spi_bus_arbiter_if bus();

  spi_bus_arbiter #(.TIMEOUT_CYCLES(TO), .MAX_BURST(MB)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  // SPI master model: done arrives m_lat cycles after the start pulse is seen
  initial begin : spi_model
    int unsigned cnt;
    logic [7:0]  held_tx;
    cnt = 0;
    held_tx = '0;
    bus.spi_done_i = 1'b0;
    bus.spi_rx_data_i = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.spi_done_i = 1'b0;
      bus.spi_rx_data_i = 8'($urandom);
      if (!rst_n) cnt = 0;
      else begin
        if (cnt != 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.spi_done_i = 1'b1;
            bus.spi_rx_data_i = held_tx ^ 8'h99;
          end
        end
        if (bus.spi_start_o) begin
          cnt = m_lat;
          held_tx = bus.spi_tx_data_o;
        end
      end
    end
  end

  initial begin : monitor
    exp_t       e;
    logic [1:0] prev_done;
    logic [1:0] cs_exp;
    prev_done = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.spi_start_o) begin
          n_start++;
          t_start = cyc;
          if (exp_tx.size() == 0) check_eq("unexpected_spi_start", 1, 0);
          else check_eq("spi_tx_data", bus.spi_tx_data_o, exp_tx.pop_front());
        end
        if (bus.done_o != 2'b00) begin
          n_done++;
          check_eq("done_width", prev_done, 2'b00);
          if (exp_q.size() == 0) check_eq("unexpected_done", bus.done_o, 2'b00);
          else begin
            e = exp_q.pop_front();
            check_eq("done_kind", e.is_to, 0);
            check_eq("done_who", bus.done_o, e.who);
            check_eq("rx_data", bus.rx_data_o, e.rx);
          end
        end
        if (bus.timeout_o) begin
          n_to++;
          if (exp_q.size() == 0) check_eq("unexpected_timeout", 1, 0);
          else begin
            e = exp_q.pop_front();
            check_eq("timeout_kind", e.is_to, 1);
            check_eq("timeout_latency", cyc - t_start, TO);
            check_eq("timeout_cs", {bus.cs_sensor_o, bus.cs_sd_o}, 2'b11);
            check_eq("timeout_gnt", bus.gnt_o, 2'b00);
          end
        end
        unique case (bus.gnt_o)
          2'b01:   cs_exp = 2'b01;
          2'b10:   cs_exp = 2'b10;
          2'b00:   cs_exp = 2'b11;
          default: cs_exp = 2'b00;
        endcase
        check_eq("gnt_onehot", bus.gnt_o != 2'b11, 1);
        check_eq("cs_vs_gnt", {bus.cs_sensor_o, bus.cs_sd_o}, cs_exp);
        prev_done = bus.done_o;
      end else prev_done = '0;
    end
  end

  task automatic wait_grant(input logic [1:0] exp, input string tag);
    int unsigned i = 0;
    while (bus.gnt_o == 2'b00 && i < 40) begin
      @(negedge clk);
      #1;
      i++;
    end
    check_eq(tag, bus.gnt_o, exp);
  endtask

  task automatic wait_release(input string tag);
    int unsigned i = 0;
    while (bus.gnt_o != 2'b00 && i < 40) begin
      @(negedge clk);
      #1;
      i++;
    end
    check_eq(tag, bus.gnt_o, 2'b00);
  endtask

  task automatic strobe(input int unsigned r, input logic [7:0] tx, input int kind);
    exp_t e;
    tick();
    if (r == 0) bus.tx_data_sensor_i = tx;
    else        bus.tx_data_sd_i = tx;
    bus.start_i = (r == 0) ? 2'b01 : 2'b10;
    exp_tx.push_back(tx);
    e.who   = (r == 0) ? 2'b01 : 2'b10;
    e.rx    = tx ^ 8'h99;
    e.is_to = (kind == K_TO);
    if (kind != K_NONE) exp_q.push_back(e);
    tick();
    bus.start_i = 2'b00;
  endtask

  task automatic send_byte(input int unsigned r, input logic [7:0] tx);
    int unsigned base = n_done;
    int unsigned i = 0;
    strobe(r, tx, K_DONE);
    while (n_done == base && i < m_lat + 30) begin
      @(negedge clk);
      #1;
      i++;
    end
    check_eq("byte_completed", n_done - base, 1);
  endtask

  initial begin : stimulus
    int unsigned cnt, base, i;
    bus.req_i = '0;
    bus.start_i = '0;
    bus.tx_data_sensor_i = '0;
    bus.tx_data_sd_i = '0;

    // reset values
    idle_cycles(3);
    check_eq("rst_gnt", bus.gnt_o, 2'b00);
    check_eq("rst_done", bus.done_o, 2'b00);
    check_eq("rst_timeout", bus.timeout_o, 0);
    check_eq("rst_spi_start", bus.spi_start_o, 0);
    check_eq("rst_tx", bus.spi_tx_data_o, 8'h00);
    check_eq("rst_rx", bus.rx_data_o, 8'h00);
    check_eq("rst_cs", {bus.cs_sensor_o, bus.cs_sd_o}, 2'b11);
    tick();
    rst_n = 1'b1;

    // sensor only, 80-cycle master latency
    tick();
    bus.req_i = 2'b01;
    wait_grant(2'b01, "sensor_only_gnt");
    check_eq("sensor_cs_low", {bus.cs_sensor_o, bus.cs_sd_o}, 2'b01);
    send_byte(0, 8'hA5);
    idle_cycles(3);
    check_eq("rx_hold", bus.rx_data_o, 8'h3C);
    tick();
    bus.req_i = 2'b00;
    i = 0;
    while (!bus.cs_sensor_o && i < 20) begin
      @(negedge clk);
      #1;
      i++;
    end
    cnt = 1;
    tick();
    bus.req_i = 2'b01;
    i = 0;
    while (i < 20) begin
      @(negedge clk);
      #1;
      if (!bus.cs_sensor_o) break;
      cnt++;
      i++;
    end
    check_eq("cs_gap", cnt, 2);
    check_eq("regrant_sensor", bus.gnt_o, 2'b01);
    tick();
    bus.req_i = 2'b00;
    wait_release("sensor_only_release");
    m_lat = 5;

    // tie out of reset, then round-robin alternation
    tick();
    rst_n = 1'b0;
    bus.req_i = 2'b11;
    tick();
    tick();
    rst_n = 1'b1;
    wait_grant(2'b01, "tie_first_sensor");
    send_byte(0, 8'h11);
    tick();
    bus.req_i = 2'b10;
    wait_release("tie_sensor_release");
    wait_grant(2'b10, "tie_then_sd");
    send_byte(1, 8'h22);
    tick();
    bus.req_i = 2'b00;
    wait_release("sd_release");
    idle_cycles(2);
    tick();
    bus.req_i = 2'b11;
    wait_grant(2'b01, "rr_sensor_after_sd");
    send_byte(0, 8'h33);
    tick();
    bus.req_i = 2'b10;
    wait_release("rr_sensor_release");
    wait_grant(2'b10, "rr_sd_after_sensor");
    tick();
    bus.req_i = 2'b00;
    wait_release("rr_sd_release");

    // SD streams with the sensor pending: preempted after MAX_BURST bytes
    tick();
    bus.req_i = 2'b10;
    wait_grant(2'b10, "sd_stream_gnt");
    for (int unsigned b = 0; b < MB; b++) begin
      if (b == 2) begin
        tick();
        bus.req_i = 2'b11;
      end
      if (b == MB - 1) check_eq("sd_no_early_release", bus.gnt_o, 2'b10);
      send_byte(1, 8'h40 + 8'(b));
    end
    wait_release("sd_preempt_release");
    wait_grant(2'b01, "sensor_after_preempt");
    send_byte(0, 8'hC0);
    tick();
    bus.req_i = 2'b10;
    wait_release("sensor_yield");
    wait_grant(2'b10, "sd_resume");
    for (int unsigned b = MB; b < 20; b++) send_byte(1, 8'h40 + 8'(b));
    tick();
    bus.req_i = 2'b00;
    wait_release("sd_stream_done");

    // sensor streams with SD pending
    tick();
    bus.req_i = 2'b01;
    wait_grant(2'b01, "sensor_stream_gnt");
    for (int unsigned b = 0; b < MB; b++) begin
      if (b == 2) begin
        tick();
        bus.req_i = 2'b11;
      end
      send_byte(0, 8'h80 + 8'(b));
    end
`ifdef ARB_FIXED_PRIORITY_EN
    idle_cycles(2);
    check_eq("sensor_not_preempted", bus.gnt_o, 2'b01);
    send_byte(0, 8'hE0);
    tick();
    bus.req_i = 2'b10;
    wait_release("sensor_stream_release");
`else
    wait_release("sensor_preempt_release");
`endif
    wait_grant(2'b10, "sd_after_sensor_stream");
    tick();
    bus.req_i = 2'b00;
    wait_release("sensor_stream_done");

    // hung master: watchdog abort, late done ignored
    m_lat = TO + 5;
    tick();
    bus.req_i = 2'b01;
    wait_grant(2'b01, "hang_gnt");
    base = n_to;
    strobe(0, 8'h5A, K_TO);
    i = 0;
    while (n_to == base && i < TO + 50) begin
      @(negedge clk);
      #1;
      i++;
    end
    check_eq("timeout_seen", n_to - base, 1);
    base = n_done;
    idle_cycles(20);
    check_eq("late_done_ignored", n_done - base, 0);
    check_eq("regrant_after_timeout", bus.gnt_o, 2'b01);
    m_lat = 6;
    send_byte(0, 8'h5B);
    tick();
    bus.req_i = 2'b00;
    wait_release("hang_release");

    // non-owner strobe is dropped
    tick();
    bus.req_i = 2'b10;
    wait_grant(2'b10, "nonowner_gnt");
    base = n_start;
    tick();
    bus.tx_data_sensor_i = 8'h77;
    bus.start_i = 2'b01;
    tick();
    bus.start_i = 2'b00;
    idle_cycles(8);
    check_eq("nonowner_no_start", n_start - base, 0);
    check_eq("nonowner_gnt_kept", bus.gnt_o, 2'b10);
    send_byte(1, 8'h88);

    // asynchronous reset mid-transfer
    m_lat = 80;
    strobe(1, 8'h99, K_NONE);
    idle_cycles(10);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus.req_i = 2'b11;
    #1;
    check_eq("async_rst_gnt", bus.gnt_o, 2'b00);
    check_eq("async_rst_cs", {bus.cs_sensor_o, bus.cs_sd_o}, 2'b11);
    check_eq("async_rst_done", bus.done_o, 2'b00);
    check_eq("async_rst_rx", bus.rx_data_o, 8'h00);
    idle_cycles(3);
    tick();
    rst_n = 1'b1;
    wait_grant(2'b01, "tie_after_reset");
    tick();
    bus.req_i = 2'b00;
    wait_release("final_release");
    idle_cycles(5);

    check_eq("scoreboard_done_empty", exp_q.size(), 0);
    check_eq("scoreboard_tx_empty", exp_tx.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end
endmodule
